rom_load_ctrl: RTL

- Sequences the HPS ioctl download stream into the game core's ROM write port, one byte at a time.
- Decodes each byte into one of four ROM regions, applies back-pressure, and captures the title number (index 1) and DIP bytes (index 254).
- Holds the game core in reset during the download and for a settle period after it.
- Sits between hps_io and fpga_druaga, replacing the ad-hoc ROMEN, tno and sw logic in the top level.

---
 rtl/rom_load_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer between hps_io and the game core: region decode, back-pressure, title/DIP capture, core reset.
// Optional build macro ROM_LOAD_CHECKSUM_EN adds a running byte checksum and gates load_done on it.
module rom_load_ctrl #(
  parameter logic [24:0] R1_BASE    = 25'h08000,
  parameter logic [24:0] R2_BASE    = 25'h0C000,
  parameter logic [24:0] R3_BASE    = 25'h10000,
  parameter logic [24:0] ROM_END    = 25'h14000,
  parameter int          SETTLE_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        rom_we,
  input  logic        rom_ready,
  output logic [1:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  tno,
  output logic [23:0] dsw,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_short
`ifdef ROM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0] checksum,
  input  logic [15:0] expect_sum
`endif
);

  localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PEND,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [24:0]      r_byte_cnt;

  logic        w_load_start;
  logic        w_rom_byte;
  logic        w_done;
  logic [1:0]  w_sel;
  logic [15:0] w_rel_addr;
  logic        w_len_ok;
  logic        w_sum_ok;
  logic        w_ok;

  function automatic logic [1:0] region_sel(input logic [24:0] a);
    if (a < R1_BASE)      return 2'd0;
    else if (a < R2_BASE) return 2'd1;
    else if (a < R3_BASE) return 2'd2;
    else                  return 2'd3;
  endfunction

  // Only the low 16 bits of the base matter for a 16-bit region-relative address.
  function automatic logic [15:0] region_base16(input logic [1:0] s);
    case (s)
      2'd1:    return R1_BASE[15:0];
      2'd2:    return R2_BASE[15:0];
      2'd3:    return R3_BASE[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  assign w_load_start = ioctl_download && (ioctl_index == 8'd0);
  assign w_rom_byte   = ioctl_wr && (ioctl_index == 8'd0) && (ioctl_addr < ROM_END);
  assign w_done       = (r_state == ST_PEND) && rom_ready;
  assign w_sel        = region_sel(ioctl_addr);
  assign w_rel_addr   = ioctl_addr[15:0] - region_base16(w_sel);
  assign w_len_ok     = (r_byte_cnt >= ROM_END);
  assign w_ok         = w_len_ok && w_sum_ok;

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] w_sum_final;

  // The byte completing on this edge must count when the load ends straight out of PEND.
  assign w_sum_final = r_sum + (w_done ? {8'h00, rom_data} : 16'h0000);
  assign w_sum_ok    = (w_sum_final == expect_sum);
  assign checksum    = r_sum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (((r_state == ST_IDLE) || (r_state == ST_RUN)) && w_load_start) begin
      r_sum <= '0;
    end else if (w_done) begin
      r_sum <= w_sum_final;
    end
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_byte_cnt <= '0;
      ioctl_wait <= 1'b0;
      rom_we     <= 1'b0;
      rom_sel    <= 2'd0;
      rom_addr   <= 16'h0000;
      rom_data   <= 8'h00;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_short <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_start) begin
            r_state    <= ST_LOAD;
            r_byte_cnt <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
          end else begin
            r_state <= ST_SETTLE;
            r_cnt   <= SETTLE_LD;
          end
        end
        ST_LOAD: begin
          core_reset <= 1'b1;
          // A byte arriving together with the end of download is written before leaving.
          if (w_rom_byte) begin
            r_state    <= ST_PEND;
            rom_we     <= 1'b1;
            ioctl_wait <= 1'b1;
            rom_sel    <= w_sel;
            rom_addr   <= w_rel_addr;
            rom_data   <= ioctl_dout;
            r_byte_cnt <= ioctl_addr + 25'd1;
          end else if (!ioctl_download) begin
            r_state    <= ST_SETTLE;
            r_cnt      <= SETTLE_LD;
            load_done  <= w_ok;
            load_short <= !w_ok;
          end
        end
        ST_PEND: begin
          core_reset <= 1'b1;
          if (rom_ready) begin
            rom_we     <= 1'b0;
            ioctl_wait <= 1'b0;
            if (ioctl_download) begin
              r_state <= ST_LOAD;
            end else begin
              r_state    <= ST_SETTLE;
              r_cnt      <= SETTLE_LD;
              load_done  <= w_ok;
              load_short <= !w_ok;
            end
          end
        end
        ST_SETTLE: begin
          // Counter is loaded on entry, so core_reset stays high for SETTLE_CYC cycles here.
          core_reset <= 1'b1;
          if ((r_cnt == '0) || (r_cnt == CNT_W'(1))) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            core_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          core_reset <= 1'b0;
          if (w_load_start) begin
            r_state    <= ST_LOAD;
            r_byte_cnt <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Title and DIP bytes are taken whatever the sequencer is doing.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tno <= 4'h0;
      dsw <= 24'h000000;
    end else if (ioctl_wr) begin
      if (ioctl_index == 8'd1) begin
        tno <= ioctl_dout[3:0];
      end else if ((ioctl_index == 8'd254) && (ioctl_addr[24:2] == 23'd0)) begin
        case (ioctl_addr[1:0])
          2'd0:    dsw[7:0]   <= ioctl_dout;
          2'd1:    dsw[15:8]  <= ioctl_dout;
          2'd2:    dsw[23:16] <= ioctl_dout;
          default: ;
        endcase
      end
    end
  end

endmodule
